// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Drives a byte-wide instruction memory with a combinational read. It issues
// four byte reads per instruction and packs them big-endian (the byte at the
// PC lands in bits [31:24]). The result goes to decode with a valid/ready
// handshake. The block owns the program counter and takes branch/jump
// redirects, which have priority over everything else.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   run               fetch enable, sampled in IDLE and at acceptance
//   mem_addr/mem_rd   byte address and live-read strobe to the memory
//   mem_data          byte returned combinationally for mem_addr
//   instr/instr_pc    assembled instruction and the address of its first byte
//   instr_valid       instr/instr_pc valid; held until instr_ready
//   instr_ready       consumer accepts instr this cycle
//   redirect(_addr)   load a new PC (unaligned values allowed)
//   fetch_count       saturating count of accepted instructions
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC_A;
            byte_cnt_q    <= 2'd0;
            instr_q       <= 32'd0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            byte_cnt_q    <= byte_cnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        byte_cnt_d    = byte_cnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d    = ST_FETCH;
                    byte_cnt_d = 2'd0;
                end
            end
            ST_FETCH: begin
                // Byte k of the instruction goes to lane 3-k (big-endian).
                case (byte_cnt_q)
                    2'd0:    instr_d[31:24] = mem_data;
                    2'd1:    instr_d[23:16] = mem_data;
                    2'd2:    instr_d[15:8]  = mem_data;
                    default: instr_d[7:0]   = mem_data;
                endcase
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    state_d       = ST_VALID;
                    instr_valid_d = 1'b1;
                    instr_pc_d    = pc_q;
                end
            end
            ST_VALID: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_d          = pc_q + ADDR_W'(4);
                    byte_cnt_d    = 2'd0;
                    if (fetch_count_q != '1) begin
                        fetch_count_d = fetch_count_q + CNT_W'(1);
                    end
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect overrides the sequencing above but leaves a handshake
        // completing on the same edge (and its count) intact.
        if (redirect) begin
            pc_d          = redirect_addr;
            byte_cnt_d    = 2'd0;
            instr_valid_d = 1'b0;
            state_d       = run ? ST_FETCH : ST_IDLE;
        end
    end

    // byte_cnt is zero outside FETCH, so mem_addr rests on the PC there.
    assign mem_addr    = pc_q + ADDR_W'(byte_cnt_q);
    assign mem_rd      = (state_q == ST_FETCH);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Bench for fetch_sequencer. A byte-array memory answers mem_addr
// combinationally. Expected instructions come from reading four consecutive
// (wrapping) bytes of that array at the PC the bench expects. Inputs are
// driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n = 1'b1;
    logic        run;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic [15:0] fetch_count;

    logic [7:0] mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    fetch_sequencer #(.ADDR_W(8), .RESET_PC(0), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fetch_count   (fetch_count)
    );

    assign mem_data = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected instruction at byte address p: four wrapping bytes, big-endian.
    function automatic logic [31:0] word_at(input logic [7:0] p);
        logic [7:0] a1, a2, a3;
        a1 = p + 8'd1;
        a2 = p + 8'd2;
        a3 = p + 8'd3;
        return {mem[p], mem[a1], mem[a2], mem[a3]};
    endfunction

    task automatic do_reset();
        run = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) on falling edges for instr_valid; ok=0 on timeout.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        run = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr got %h want 00", mem_addr); else n_pass++;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got %b want 0", mem_rd); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr got %h want 0", instr); else n_pass++;
        n_checks++; if (instr_pc !== 8'h00) $display("FAIL reset_instr_pc got %h want 00", instr_pc); else n_pass++;
        n_checks++; if (fetch_count !== 16'd0) $display("FAIL reset_count got %0d want 0", fetch_count); else n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL idle_mem_rd got %b want 0", mem_rd); else n_pass++;
        ok = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        run = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (mem_addr !== 8'(i)) $display("FAIL basic_addr%0d got %h want %h", i, mem_addr, 8'(i)); else n_pass++;
            n_checks++; if (mem_rd !== 1'b1) $display("FAIL basic_rd%0d got %b want 1", i, mem_rd); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", instr_valid); else n_pass++;
        n_checks++; if (instr !== 32'h12345678) $display("FAIL basic_instr got %h want 12345678", instr); else n_pass++;
        n_checks++; if (instr_pc !== 8'h00) $display("FAIL basic_pc got %h want 00", instr_pc); else n_pass++;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL basic_valid_rd got %b want 0", mem_rd); else n_pass++;
        @(negedge clk);
        n_checks++; if (mem_addr !== 8'h04) $display("FAIL basic_next_addr got %h want 04", mem_addr); else n_pass++;
        n_checks++; if (mem_rd !== 1'b1) $display("FAIL basic_next_rd got %b want 1", mem_rd); else n_pass++;
        n_checks++; if (fetch_count !== 16'd1) $display("FAIL basic_count got %0d want 1", fetch_count); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", instr_valid); else n_pass++;
        $display("basic: instr_pc=00 instr=12345678 delivered");
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] exp_w;
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        exp_w = word_at(8'h00);
        run = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        wait_valid(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL bp_timeout got %b want 1", ok); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (instr !== exp_w) $display("FAIL bp_hold_instr got %h want %h", instr, exp_w); else n_pass++;
            n_checks++; if (instr_pc !== 8'h00) $display("FAIL bp_hold_pc got %h want 00", instr_pc); else n_pass++;
            n_checks++; if (instr_valid !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", instr_valid); else n_pass++;
            n_checks++; if (mem_rd !== 1'b0) $display("FAIL bp_rd got %b want 0", mem_rd); else n_pass++;
            n_checks++; if (mem_addr !== 8'h00) $display("FAIL bp_addr got %h want 00", mem_addr); else n_pass++;
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_checks++; if (fetch_count !== 16'd1) $display("FAIL bp_count got %0d want 1", fetch_count); else n_pass++;
        n_checks++; if (mem_addr !== 8'h04) $display("FAIL bp_next_addr got %h want 04", mem_addr); else n_pass++;
        $display("backpressure: instr=%h held 6 cycles then accepted", exp_w);
    endtask

    task automatic test_redirect_fetch();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 8'($urandom);
        run = 1'b1; instr_ready = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        // byte_cnt is 2 here; the redirect replaces that capture edge.
        redirect = 1'b1; redirect_addr = 8'h40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            redirect = 1'b0;
            n_checks++; if (mem_addr !== 8'(8'h40 + i)) $display("FAIL rf_addr%0d got %h want %h", i, mem_addr, 8'(8'h40 + i)); else n_pass++;
        end
        @(negedge clk);
        wait_valid(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL rf_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (instr_pc !== 8'h40) $display("FAIL rf_pc got %h want 40", instr_pc); else n_pass++;
        n_checks++; if (instr !== word_at(8'h40)) $display("FAIL rf_instr got %h want %h", instr, word_at(8'h40)); else n_pass++;
        $display("redirect_fetch: instr_pc=40 instr=%h", word_at(8'h40));
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
        run = 1'b1; instr_ready = 1'b0;
        redirect = 1'b1; redirect_addr = 8'hFE;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++; if (mem_addr !== 8'hFE) $display("FAIL wrap_addr0 got %h want FE", mem_addr); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_addr !== 8'h00) $display("FAIL wrap_addr2 got %h want 00", mem_addr); else n_pass++;
        @(negedge clk); @(negedge clk);
        wait_valid(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL wrap_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (instr !== 32'hAABBCCDD) $display("FAIL wrap_instr got %h want AABBCCDD", instr); else n_pass++;
        n_checks++; if (instr_pc !== 8'hFE) $display("FAIL wrap_pc got %h want FE", instr_pc); else n_pass++;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_checks++; if (mem_addr !== 8'h02) $display("FAIL wrap_next got %h want 02", mem_addr); else n_pass++;
        $display("wrap: instr_pc=FE instr=AABBCCDD next=02");
    endtask

    task automatic test_redirect_accept();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) mem[8'h20 + i] = 8'($urandom);
        run = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        wait_valid(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL ra_timeout got %b want 1", ok); else n_pass++;
        instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 8'h20;
        @(negedge clk);
        instr_ready = 1'b0; redirect = 1'b0;
        n_checks++; if (fetch_count !== 16'd1) $display("FAIL ra_count got %0d want 1", fetch_count); else n_pass++;
        n_checks++; if (mem_addr !== 8'h20) $display("FAIL ra_addr got %h want 20", mem_addr); else n_pass++;
        wait_valid(ok);
        n_checks++; if (instr_pc !== 8'h20) $display("FAIL ra_pc got %h want 20", instr_pc); else n_pass++;
        n_checks++; if (instr !== word_at(8'h20)) $display("FAIL ra_instr got %h want %h", instr, word_at(8'h20)); else n_pass++;
        $display("redirect_accept: count=1 next instr_pc=20");
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        // One full instruction first so the reset has non-zero state to clear.
        repeat (6) @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_addr !== 8'h05) $display("FAIL ar_pre_addr got %h want 05", mem_addr); else n_pass++;
        n_checks++; if (fetch_count !== 16'd1) $display("FAIL ar_pre_count got %0d want 1", fetch_count); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL ar_rd got %b want 0", mem_rd); else n_pass++;
        n_checks++; if (mem_addr !== 8'h00) $display("FAIL ar_addr got %h want 00", mem_addr); else n_pass++;
        n_checks++; if (fetch_count !== 16'd0) $display("FAIL ar_count got %0d want 0", fetch_count); else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL ar_instr got %h want 0", instr); else n_pass++;
        n_checks++; if (instr_pc !== 8'h00) $display("FAIL ar_instr_pc got %h want 00", instr_pc); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL ar_valid got %b want 0", instr_valid); else n_pass++;
        run = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (mem_rd !== 1'b0) $display("FAIL ar_idle_rd got %b want 0", mem_rd); else n_pass++;
        end
        ok = 1'b1;
        $display("async_reset: cleared mid-fetch, idle after release");
    endtask

    task automatic test_run_low();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        run = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        wait_valid(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL rl_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (instr !== word_at(8'h00)) $display("FAIL rl_instr got %h want %h", instr, word_at(8'h00)); else n_pass++;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_checks++; if (fetch_count !== 16'd1) $display("FAIL rl_count got %0d want 1", fetch_count); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (mem_rd !== 1'b0) $display("FAIL rl_idle_rd got %b want 0", mem_rd); else n_pass++;
            n_checks++; if (mem_addr !== 8'h04) $display("FAIL rl_idle_addr got %h want 04", mem_addr); else n_pass++;
        end
        $display("run_low: instr=%h completed then idle", word_at(8'h00));
    endtask

    task automatic test_random();
        bit ok;
        bit stop, redir;
        logic [7:0]  model_pc;
        logic [15:0] model_count;
        logic [7:0]  raddr;
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        model_pc = 8'h00; model_count = 16'd0;
        run = 1'b1;
        for (int t = 0; t < 40; t++) begin
            wait_valid(ok);
            n_checks++; if (ok !== 1'b1) $display("FAIL rnd_timeout txn %0d got %b want 1", t, ok); else n_pass++;
            n_checks++; if (instr_pc !== model_pc) $display("FAIL rnd_pc txn %0d got %h want %h", t, instr_pc, model_pc); else n_pass++;
            n_checks++; if (instr !== word_at(model_pc)) $display("FAIL rnd_instr txn %0d got %h want %h", t, instr, word_at(model_pc)); else n_pass++;
            $display("txn %0d: instr_pc=%h instr=%h", t, instr_pc, instr);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            stop  = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 1) == 1);
            raddr = 8'($urandom);
            instr_ready = 1'b1; redirect = redir; redirect_addr = raddr; run = !stop;
            @(negedge clk);
            instr_ready = 1'b0; redirect = 1'b0;
            model_count = model_count + 16'd1;
            model_pc = redir ? raddr : model_pc + 8'd4;
            n_checks++; if (fetch_count !== model_count) $display("FAIL rnd_count txn %0d got %0d want %0d", t, fetch_count, model_count); else n_pass++;
            if (stop) begin
                @(negedge clk);
                n_checks++; if (mem_rd !== 1'b0) $display("FAIL rnd_idle txn %0d got %b want 0", t, mem_rd); else n_pass++;
                run = 1'b1;
                @(negedge clk);
            end else if ($urandom_range(0, 2) == 0) begin
                // Abort the fetch in progress after a few bytes.
                repeat ($urandom_range(0, 3)) @(negedge clk);
                raddr = 8'($urandom);
                redirect = 1'b1; redirect_addr = raddr;
                @(negedge clk);
                redirect = 1'b0;
                model_pc = raddr;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        run = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_fetch();
        test_wrap();
        test_redirect_accept();
        test_async_reset();
        test_run_low();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the byte-wide, 256-entry instruction memory. The memory has a combinational read, and each access returns one byte.
- Issues four byte reads per instruction and assembles them big-endian: the byte at the PC goes to bits [31:24].
- Presents the 32-bit instruction to decode with a valid/ready handshake.
- Owns the program counter and accepts branch/jump redirects from the datapath.

Parameters:
- ADDR_W, 8: address width. Memory depth is 2**ADDR_W bytes and all address arithmetic wraps modulo 2**ADDR_W.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: width of the delivered-instruction counter.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  fetch enable; sampled only at the IDLE state and at instruction acceptance
- mem_addr  out  ADDR_W  byte address to instruction memory
- mem_rd  out  1  high when mem_addr is a live read (FETCH state)
- mem_data  in  8  byte returned combinationally for mem_addr
- instr  out  32  assembled instruction
- instr_pc  out  ADDR_W  address of the first byte of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  consumer accepts instr this cycle
- redirect  in  1  load new PC (branch/jump)
- redirect_addr  in  ADDR_W  new PC; unaligned values are legal
- fetch_count  out  CNT_W  instructions accepted since reset, saturating

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, byte_cnt=0
  - instr=0, instr_pc=0, instr_valid=0, mem_rd=0, fetch_count=0
  - mem_addr=RESET_PC (mem_addr always equals pc+byte_cnt)
- IDLE:
  - mem_rd=0.
  - If run=1 at the clock edge: go to FETCH with byte_cnt=0.
- FETCH:
  - mem_rd=1; mem_addr = (pc + byte_cnt) mod 2**ADDR_W.
  - Each edge captures mem_data into byte lane 3-byte_cnt of instr; byte_cnt 0 lands in [31:24].
  - byte_cnt increments each edge. On the edge capturing byte_cnt=3: go to VALID, set instr_valid=1 and instr_pc=pc.
  - instr is not guaranteed stable while in FETCH; only VALID-state values are meaningful.
- VALID:
  - instr, instr_pc and instr_valid are held stable until instr_ready=1.
  - On an edge with instr_ready=1:
    - instr_valid goes 0, pc becomes pc+4 (wrapping), fetch_count increments (saturating at all-ones).
    - Next state is FETCH (byte_cnt=0) if run=1, else IDLE.
- Latency: with run=1 sampled in IDLE at edge E, bytes are captured at E+1..E+4 and instr_valid is high after E+4.
- Throughput: with instr_ready held high, one instruction every 5 cycles.
- Redirect (any state, highest priority):
  - At the edge: pc=redirect_addr, byte_cnt=0, instr_valid=0, and any partial assembly is discarded.
  - Next state is FETCH if run=1, else IDLE.
- Redirect and instr_ready together in VALID:
  - The handshake completes and fetch_count increments.
  - PC takes redirect_addr, not pc+4.
- run=0 during FETCH: the current instruction completes and is delivered; run is re-sampled at acceptance.
- Wrap-around: a fetch starting at 2**ADDR_W-2 reads FE,FF,00,01 (ADDR_W=8), and the next pc is 02.
- Reset asserted mid-fetch or in VALID: all state returns to reset values immediately, with no completion of the pending instruction.

Test Plan:
- Reset, then memory[0..3]=12,34,56,78 and run=1 with instr_ready=1 → mem_addr steps 00,01,02,03 with mem_rd=1; instr=32'h12345678, instr_pc=00, instr_valid high after the 4th capture edge; next fetch starts at mem_addr=04; fetch_count=1.
- Backpressure: instr_ready=0 for 6 cycles in VALID → instr/instr_pc held constant, mem_rd=0, pc not advanced; ready=1 → one handshake, fetch_count increments by exactly 1.
- Redirect during FETCH at byte_cnt=2 with redirect_addr=8'h40 → partial bytes discarded; next mem_addr=40, then 41,42,43; delivered instr_pc=40, holding memory[40..43].
- Wrap: redirect_addr=8'hFE, memory FE,FF,00,01=AA,BB,CC,DD → instr=32'hAABBCCDD, instr_pc=FE; next fetch mem_addr=00+2=02.
- Simultaneous redirect=1 (addr 8'h20) and instr_ready=1 in VALID → fetch_count increments; next instr_pc=20, not pc+4.
- Mid-operation: rst_n low during FETCH byte 1 → outputs go to reset values asynchronously (before the next edge); after release with run=0 the block stays IDLE with mem_rd=0. Separately, run=0 while in FETCH → the instruction still completes; after acceptance the block goes IDLE.
